// File: rtl/mar_arb_pkg.sv
// Shared types and widths for the MAR access arbiter.
// State encoding, requester IDs and the round-robin tie-break helper.
package mar_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } req_id_t;

  // On a tie the requester that was not served last wins.
  function automatic req_id_t rr_pick(
    input logic    fetch,
    input logic    exec,
    input req_id_t last
  );
    if (fetch && exec)
      return (last == EXEC) ? FETCH : EXEC;
    return exec ? EXEC : FETCH;
  endfunction

endpackage

// File: rtl/mar_arb_wait_cnt.sv
// 4-bit READ wait counter with clear, enable and terminal count.
// Terminal count flags the last wait cycle, i.e. count == LIMIT-1.
module mar_arb_wait_cnt #(
  parameter logic [3:0] LIMIT = 4'd1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iEn,
  output logic oTc
);

  logic [3:0] cnt;

  always_ff @(posedge iClk) begin
    if (!iRst_n)
      cnt <= 4'd0;
    else if (iClr)
      cnt <= 4'd0;
    else if (iEn)
      cnt <= cnt + 4'd1;
  end

  assign oTc = (cnt == LIMIT - 4'd1);

endmodule

// File: rtl/mar_access_arbiter.sv
// Arbitrates fetch/execute access to the MAR and memory read path.
// Build option: define MAR_ARB_RR_EN for round-robin tie-breaking.
module mar_access_arbiter
  import mar_arb_pkg::*;
#(
  parameter int unsigned RD_WAIT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFetchReq,
  input  logic [ADDR_W-1:0] iFetchAddr,
  output logic              oFetchGnt,
  output logic              oFetchDone,
  input  logic              iExecReq,
  input  logic [ADDR_W-1:0] iExecAddr,
  output logic              oExecGnt,
  output logic              oExecDone,
  output logic [ADDR_W-1:0] oMarData,
  output logic              oMarLoad,
  output logic              oMemRd,
  input  logic [DATA_W-1:0] iMemData,
  output logic [DATA_W-1:0] oRdData,
  output logic              oBusy
);

  state_t            state;
  state_t            state_nxt;
  req_id_t           winner;
  req_id_t           pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              any_req;
  logic              grant;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;

  assign any_req = iFetchReq | iExecReq;
  assign grant   = (state == IDLE) && any_req;

`ifdef MAR_ARB_RR_EN
  req_id_t last;

  assign pick = rr_pick(iFetchReq, iExecReq, last);

  always_ff @(posedge iClk) begin
    if (!iRst_n)
      last <= FETCH;
    else if (grant)
      last <= pick;
  end
`else
  assign pick = iExecReq ? EXEC : FETCH;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (any_req)
          state_nxt = LOAD;
      end
      LOAD: begin
        cnt_clr   = 1'b1;
        state_nxt = READ;
      end
      READ: begin
        cnt_en = 1'b1;
        if (cnt_tc)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner and address are latched at the sampling edge and held
  // until the next grant, so oMarData keeps the last granted address.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      winner <= FETCH;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (grant) begin
        winner <= pick;
        addr_q <= (pick == EXEC) ? iExecAddr : iFetchAddr;
      end
      if (state == READ && cnt_tc)
        data_q <= iMemData;
    end
  end

  mar_arb_wait_cnt #(
    .LIMIT (4'(RD_WAIT))
  ) u_wait_cnt (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (cnt_clr),
    .iEn    (cnt_en),
    .oTc    (cnt_tc)
  );

  assign oMarLoad   = (state == LOAD);
  assign oMemRd     = (state == READ);
  assign oBusy      = (state != IDLE);
  assign oFetchGnt  = (state == LOAD) && (winner == FETCH);
  assign oExecGnt   = (state == LOAD) && (winner == EXEC);
  assign oFetchDone = (state == DONE) && (winner == FETCH);
  assign oExecDone  = (state == DONE) && (winner == EXEC);
  assign oMarData   = addr_q;
  assign oRdData    = data_q;

endmodule

// File: tb/tb_mar_access_arbiter.sv
// Scoreboard bench for mar_access_arbiter (RD_WAIT=2 main DUT,
// plus an RD_WAIT=1 instance for the short-latency case).
module tb_mar_access_arbiter;

  localparam int RDW = 2;

  typedef struct {
    logic        id;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        iClk = 1'b0;
  logic        iRst_n;

  logic        fetch_req, exec_req;
  logic [15:0] fetch_addr, exec_addr;
  logic [7:0]  mem_data;
  logic        fetch_gnt, fetch_done, exec_gnt, exec_done;
  logic [15:0] mar_data;
  logic        mar_load, mem_rd, busy;
  logic [7:0]  rd_data;

  logic        s_fetch_req, s_exec_req;
  logic [15:0] s_fetch_addr, s_exec_addr;
  logic [7:0]  s_mem_data;
  logic        s_fetch_gnt, s_fetch_done, s_exec_gnt, s_exec_done;
  logic [15:0] s_mar_data;
  logic        s_mar_load, s_mem_rd, s_busy;
  logic [7:0]  s_rd_data;

  exp_t gnt_q[$];
  exp_t done_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   rd_cnt = 0;

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  mar_access_arbiter #(.RD_WAIT(RDW)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iFetchReq  (fetch_req),
    .iFetchAddr (fetch_addr),
    .oFetchGnt  (fetch_gnt),
    .oFetchDone (fetch_done),
    .iExecReq   (exec_req),
    .iExecAddr  (exec_addr),
    .oExecGnt   (exec_gnt),
    .oExecDone  (exec_done),
    .oMarData   (mar_data),
    .oMarLoad   (mar_load),
    .oMemRd     (mem_rd),
    .iMemData   (mem_data),
    .oRdData    (rd_data),
    .oBusy      (busy)
  );

  mar_access_arbiter #(.RD_WAIT(1)) dut1 (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iFetchReq  (s_fetch_req),
    .iFetchAddr (s_fetch_addr),
    .oFetchGnt  (s_fetch_gnt),
    .oFetchDone (s_fetch_done),
    .iExecReq   (s_exec_req),
    .iExecAddr  (s_exec_addr),
    .oExecGnt   (s_exec_gnt),
    .oExecDone  (s_exec_done),
    .oMarData   (s_mar_data),
    .oMarLoad   (s_mar_load),
    .oMemRd     (s_mem_rd),
    .iMemData   (s_mem_data),
    .oRdData    (s_rd_data),
    .oBusy      (s_busy)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got === exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic push(input logic id, input logic [15:0] a,
                      input logic [7:0] d, input bit with_done);
    exp_t e;
    e.id = id;
    e.addr = a;
    e.data = d;
    gnt_q.push_back(e);
    if (with_done)
      done_q.push_back(e);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((gnt_q.size() != 0 || done_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check(name, gnt_q.size() + done_q.size(), 0);
    gnt_q.delete();
    done_q.delete();
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or done.
  always @(negedge iClk) begin
    exp_t e;
    if (iRst_n) begin
      if (fetch_gnt && exec_gnt)
        check("dual_gnt", 1, 0);
      if (fetch_done && exec_done)
        check("dual_done", 1, 0);
      if (fetch_gnt || exec_gnt) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 1, 0);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_id", exec_gnt, e.id);
          check("gnt_addr", mar_data, e.addr);
          check("gnt_load", mar_load, 1);
        end
        gnt_cyc = cyc;
        rd_cnt = 0;
      end
      if (mem_rd)
        rd_cnt++;
      if (fetch_done || exec_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = done_q.pop_front();
          check("done_id", exec_done, e.id);
          check("done_data", rd_data, e.data);
          check("done_latency", cyc - gnt_cyc, RDW + 1);
          check("rd_cycles", rd_cnt, RDW);
        end
      end
    end
  end

  initial begin
    int n;
    int done_at;
    int rd;
    iRst_n = 1'b0;
    fetch_req = 1'b1;
    exec_req = 1'b1;
    fetch_addr = 16'h0010;
    exec_addr = 16'h0020;
    mem_data = 8'hA5;
    s_fetch_req = 1'b0;
    s_exec_req = 1'b0;
    s_fetch_addr = 16'h0000;
    s_exec_addr = 16'h0000;
    s_mem_data = 8'h00;

    repeat (3) begin
      tick();
      check("rst_outputs",
            {fetch_gnt, fetch_done, exec_gnt, exec_done, mar_data,
             mar_load, mem_rd, rd_data, busy}, 0);
      check("rst_outputs_rw1",
            {s_fetch_gnt, s_fetch_done, s_exec_gnt, s_exec_done,
             s_mar_data, s_mar_load, s_mem_rd, s_rd_data, s_busy}, 0);
    end

`ifdef MAR_ARB_RR_EN
    push(1'b1, 16'h0020, 8'hA5, 1);
    push(1'b0, 16'h0010, 8'hA5, 1);
    push(1'b1, 16'h0020, 8'hA5, 1);
    push(1'b0, 16'h0010, 8'hA5, 1);
`else
    repeat (4) push(1'b1, 16'h0020, 8'hA5, 1);
`endif
    iRst_n = 1'b1;
    n = 0;
    while (gnt_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    fetch_req = 1'b0;
    exec_req = 1'b0;
    wait_empty("order_drain");
    check("idle_busy", busy, 0);
`ifdef MAR_ARB_RR_EN
    check("mar_hold", mar_data, 16'h0010);
`else
    check("mar_hold", mar_data, 16'h0020);
`endif

    fetch_addr = 16'h0004;
    mem_data = 8'h3A;
    push(1'b0, 16'h0004, 8'h3A, 1);
    fetch_req = 1'b1;
    tick();
    check("fetch_gnt_direct", fetch_gnt, 1);
    fetch_req = 1'b0;
    wait_empty("fetch_drain");
    tick();
    check("rd_hold", rd_data, 8'h3A);
    check("mar_hold_fetch", mar_data, 16'h0004);

    exec_addr = 16'h0042;
    mem_data = 8'h7E;
    push(1'b1, 16'h0042, 8'h7E, 1);
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    wait_empty("exec_drop_drain");

    exec_addr = 16'h0030;
    mem_data = 8'h11;
    push(1'b1, 16'h0030, 8'h11, 0);
    exec_req = 1'b1;
    tick();
    exec_req = 1'b0;
    tick();
    check("abort_in_read", mem_rd, 1);
    iRst_n = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_memrd", mem_rd, 0);
    check("abort_rd_data", rd_data, 8'h00);
    check("abort_done", exec_done, 0);
    iRst_n = 1'b1;
    repeat (6) tick();
    check("abort_gnt_seen", gnt_q.size(), 0);
    check("abort_no_done", busy, 0);

    s_exec_addr = 16'h0077;
    s_mem_data = 8'h99;
    s_exec_req = 1'b1;
    done_at = 0;
    rd = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        check("rw1_gnt", {s_exec_gnt, s_mar_data}, {1'b1, 16'h0077});
        s_exec_req = 1'b0;
      end
      if (s_mem_rd)
        rd++;
      if (s_exec_done && done_at == 0)
        done_at = i;
    end
    check("rw1_latency", done_at, 3);
    check("rw1_rd_cycles", rd, 1);
    check("rw1_data", s_rd_data, 8'h99);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
